// File: rtl/anfsqrt_sqriu.sv
// -----------------------------------------------------------------------------
// anfsqrt_sqriu -- sequential squarer, the inverse of the iterative sqrt unit.
//
// Computes sq = opnd * opnd with one shift-and-add step per clock, walking the
// multiplier bits LSB first. The result appears W cycles after the edge that
// accepted start, marked by a one-cycle done pulse.
//
// Optional feature macro: ANFSQRT_SQRIU_CHECK_EN
//   When defined, a radicand chk_x_i is latched together with the operand and
//   chk_ok_o reports whether the operand is floor(sqrt(chk_x_i)).
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start_i    in   request a new squaring (accepted only when idle)
//   opnd_i     in   W-bit operand, latched on acceptance
//   chk_x_i    in   2W-bit radicand to check (CHECK_EN only)
//   busy_o     out  high while iterations are running
//   done_o     out  one-cycle pulse, sq_o valid
//   sq_o       out  2W-bit registered square, held until the next done
//   chk_ok_o   out  floor-sqrt check result, updated with done (CHECK_EN only)
// -----------------------------------------------------------------------------
module anfsqrt_sqriu #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic [W-1:0]   opnd_i,
`ifdef ANFSQRT_SQRIU_CHECK_EN
  input  logic [2*W-1:0] chk_x_i,
  output logic           chk_ok_o,
`endif
  output logic           busy_o,
  output logic           done_o,
  output logic [2*W-1:0] sq_o
);

  // Bit-index width and iteration counter width (counter is at least 5 bits).
  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam int CW = ((IW + 1) > 5) ? (IW + 1) : 5;
  localparam logic [CW-1:0] LAST_IT = CW'(W - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     opnd_q,  opnd_d;
  logic [2*W-1:0]   acc_q,   acc_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [2*W-1:0]   sq_q,    sq_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  logic [IW-1:0]    bit_idx_s;
  logic             bit_s;
  logic [2*W-1:0]   addend_s;
  logic [2*W-1:0]   acc_step_s;

`ifdef ANFSQRT_SQRIU_CHECK_EN
  logic [2*W-1:0]   chk_x_q,  chk_x_d;
  logic             chk_ok_q, chk_ok_d;
  logic [2*W:0]     sq_ext_s;
  logic [2*W:0]     next_sq_s;
  logic             chk_ok_s;
`endif

  // One shift-and-add step: add opnd << i when multiplier bit i is set.
  // The sum never exceeds (2^W-1)^2, so 2W bits cannot overflow.
  always_comb begin
    bit_idx_s  = cnt_q[IW-1:0];
    bit_s      = opnd_q[bit_idx_s];
    addend_s   = {{W{1'b0}}, opnd_q} << bit_idx_s;
    if (bit_s) begin
      acc_step_s = acc_q + addend_s;
    end else begin
      acc_step_s = acc_q;
    end
  end

`ifdef ANFSQRT_SQRIU_CHECK_EN
  // floor-sqrt test: r*r <= x < r*r + 2r + 1, evaluated one bit wider.
  always_comb begin
    sq_ext_s  = {1'b0, acc_step_s};
    next_sq_s = sq_ext_s + {{W{1'b0}}, opnd_q, 1'b1};
    chk_ok_s  = (sq_ext_s <= {1'b0, chk_x_q}) && (next_sq_s > {1'b0, chk_x_q});
  end
`endif

  // Next-state and datapath control for the IDLE/RUN sequencer.
  always_comb begin
    state_d  = state_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sq_d     = sq_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef ANFSQRT_SQRIU_CHECK_EN
    chk_x_d  = chk_x_q;
    chk_ok_d = chk_ok_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          opnd_d  = opnd_i;
          acc_d   = {(2*W){1'b0}};
          cnt_d   = {CW{1'b0}};
          busy_d  = 1'b1;
`ifdef ANFSQRT_SQRIU_CHECK_EN
          chk_x_d = chk_x_i;
`endif
        end else begin
          busy_d  = 1'b0;
        end
      end
      ST_RUN: begin
        acc_d = acc_step_s;
        if (cnt_q == LAST_IT) begin
          // Final iteration: publish the result and return to idle in the
          // same edge so a start in the done cycle is taken without a bubble.
          state_d  = ST_IDLE;
          sq_d     = acc_step_s;
          cnt_d    = {CW{1'b0}};
          busy_d   = 1'b0;
          done_d   = 1'b1;
`ifdef ANFSQRT_SQRIU_CHECK_EN
          chk_ok_d = chk_ok_s;
`endif
        end else begin
          cnt_d    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CW{1'b0}};
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      opnd_q   <= {W{1'b0}};
      acc_q    <= {(2*W){1'b0}};
      cnt_q    <= {CW{1'b0}};
      sq_q     <= {(2*W){1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ANFSQRT_SQRIU_CHECK_EN
      chk_x_q  <= {(2*W){1'b0}};
      chk_ok_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sq_q     <= sq_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef ANFSQRT_SQRIU_CHECK_EN
      chk_x_q  <= chk_x_d;
      chk_ok_q <= chk_ok_d;
`endif
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign sq_o     = sq_q;
`ifdef ANFSQRT_SQRIU_CHECK_EN
  assign chk_ok_o = chk_ok_q;
`endif

endmodule

// File: doc/anfsqrt_sqriu.md
ANFSQRT_SQRIU -- requirements
Module: anfsqrt_sqriu

Interface
REQ-001 Parameter: W, 16, operand width in bits; result width is 2*W.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to square opnd; sampled on rising edge of clk.
REQ-005 opnd  input  W  root candidate to square; sampled only when start is accepted.
REQ-006 busy  output  1  high while an iteration sequence is in progress.
REQ-007 done  output  1  one-cycle pulse marking sq valid for the completed operation.
REQ-008 sq  output  2*W  registered result opnd*opnd; holds last result until next done.
REQ-009 chk_x  input  2*W  radicand to check against opnd (present only with ANFSQRT_SQRIU_CHECK_EN).
REQ-010 chk_ok  output  1  high when opnd is floor-sqrt of chk_x (present only with ANFSQRT_SQRIU_CHECK_EN).

Function
REQ-011 The block SHALL be the inverse of the iterative square-root unit: it SHALL compute r*r sequentially by shift-and-add, one multiplier bit per clock, LSB first.
REQ-012 States SHALL be IDLE and RUN; IDLE -> RUN on accepted start; RUN -> IDLE after the W-th iteration.
REQ-013 start SHALL be accepted only in IDLE; start while busy SHALL be ignored and SHALL NOT alter operand, counter or accumulator.
REQ-014 On acceptance at edge k: opnd latched, accumulator cleared, 5-bit-min iteration counter cleared, busy high after edge k.
REQ-015 Edges k+1 .. k+W SHALL each perform one iteration: if current multiplier bit set, accumulator += (opnd << bit index), truncated to 2*W bits (no overflow possible).
REQ-016 After edge k+W: sq loaded with accumulator, done high for exactly one cycle, busy low; latency start-edge to done = W cycles (16 at default).
REQ-017 start asserted in the cycle done is high SHALL be accepted (back-to-back operation, no bubble beyond the done cycle).
REQ-018 busy and done SHALL never be high in the same cycle.
REQ-019 sq SHALL change only on the edge that raises done.
REQ-020 opnd changes after acceptance SHALL NOT affect the running result.

Reset
REQ-021 rst_n low SHALL immediately force IDLE, busy=0, done=0, sq=0, counter=0, accumulator=0, latched operand=0.
REQ-022 Reset mid-operation SHALL abandon the operation; no done pulse SHALL follow reset release.
REQ-023 First start is accepted on the first rising edge with rst_n high.

Configuration
REQ-024 Macro ANFSQRT_SQRIU_CHECK_EN: when defined, chk_x and chk_ok exist; chk_x latched with opnd at acceptance.
REQ-025 With macro: on the done edge chk_ok SHALL be registered as (r*r <= chk_x) AND (r*r + 2r + 1 > chk_x), using 2*W+1-bit compare; held until next done; reset value 0.
REQ-026 Without macro: ports chk_x and chk_ok and all related logic SHALL be absent; all other behaviour identical.

Verification
REQ-027 Reset, then start with opnd=3 -> busy for 16 cycles, done pulse once, sq=9.
REQ-028 opnd=65535 -> sq=4294836225 (0xFFFE0001); opnd=0 -> sq=0, done still after 16 cycles.
REQ-029 start opnd=5 then start opnd=7 at cycle 4 while busy -> ignored; sq=25; start in done cycle with opnd=7 -> sq=49, 16 cycles later.
REQ-030 Assert rst_n low at iteration 8 of opnd=200 -> all outputs 0 immediately; no done after release; sq stays 0.
REQ-031 CHECK_EN: opnd=10, chk_x=100 -> chk_ok=1; chk_x=99 -> chk_ok=0; chk_x=120 -> chk_ok=1; chk_x=121 -> chk_ok=0.
REQ-032 Without CHECK_EN: elaboration without chk_x/chk_ok; REQ-027..REQ-030 pass unchanged.
